gpu_bus_bridge: RTL and testbench
=================================

# gpu_bus_bridge

Front end between the 6502-side GPU bus (`data`, `addr`, `rw`, `cs_clock`) and the write ports of the tile, attribute and color memories, in the `CLK100MHz` domain. It synchronizes the asynchronous `cs_clock` strobe and decodes a small register file: address pointer, control, and data port. Data-port writes are queued in a FIFO and drained one entry per clock into single-cycle memory write strobes, optionally only during `vga_blank`.

## Interface
- `FIFO_DEPTH`, default 16: queue entries; power of two.
- `FIFO_AW`, default 4: log2(`FIFO_DEPTH`).
- `CLK100MHz` in 1: the only clock; everything is registered on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `data` in 8: CPU write data.
- `addr` in 3: register select.
- `rw` in 1: 1 = CPU read, 0 = CPU write.
- `cs_clock` in 1: chip-select strobe, asynchronous to `CLK100MHz`.
- `vga_blank` in 1: from the sync generator; 1 = blanking.
- `tile_memory_write_enable` out 1; `tile_memory_write_addr` out 11; `tile_memory_write_data` out 8.
- `attribute_memory_write_enable` out 1; `attribute_memory_write_addr` out 12; `attribute_memory_write_data` out 8.
- `color_memory_write_enable` out 1; `color_memory_write_addr` out 4; `color_memory_write_data` out 8.
- `fifo_level` out `FIFO_AW`+1: current entry count, 0..`FIFO_DEPTH`.
- `overflow` out 1: sticky flag, set when a push is dropped.

## Operation
- **Strobe sync:** `cs_clock` passes through 2 flops (s1, s2). A third flop s3 holds the previous s2. `commit` = s3 & ~s2, a one-cycle pulse on each falling edge of `cs_clock`.
- **Bus capture:** holding registers load `addr`/`data`/`rw` every cycle while s1 = 1. The top level guarantees these signals are stable while `cs_clock` is high and for ≥30 ns after its fall. `commit` acts on the held values.
- **Read cycles:** a commit with held `rw` = 1 is ignored.
- **Unused addresses:** held `addr` 4–7 are ignored.
- **Register map (writes only):**
  - 0 ADDR_LO: ptr[7:0] ← data.
  - 1 ADDR_HI: ptr[11:8] ← data[3:0]; data[7:4] ignored.
  - 2 CTRL: target ← data[1:0] (0 tile, 1 attribute, 2 color, 3 discard); autoinc ← data[2]; blank_only ← data[3]; data[7] = 1 clears `overflow`; data[6:4] ignored.
  - 3 DATA: push {target, ptr, data} into the FIFO. If autoinc = 1, ptr ← ptr+1 mod 4096; wrap from 0xFFF to 0x000.
- **Target 3:** nothing is pushed. ptr still auto-increments.
- **FIFO full:** the push is dropped, `overflow` ← 1, and ptr still auto-increments so CPU streams stay aligned.
  - Fullness is judged on the pre-edge count. A push into a full FIFO is dropped even if a pop occurs on the same edge.
- **Drain:** pop when the FIFO is non-empty and (blank_only = 0 or `vga_blank` = 1). blank_only is the current CTRL value, not a per-entry copy.
- **On pop:** only the addressed target's `*_write_enable` goes 1 for one cycle. Its address output gets the entry ptr truncated: tile [10:0], attribute [11:0], color [3:0]. Its data output gets the entry data.
  - Enables drop to 0 on the next cycle unless another pop occurs.
  - Address/data outputs hold their last value when idle.
- **Push and pop on the same edge:** both occur when the FIFO is neither full nor empty; `fifo_level` is unchanged.
- **Ordering:** entries drain strictly FIFO. Queued entries are unaffected by later ADDR/CTRL writes.

## Timing
- **Reset values:** ptr = 0, CTRL = target 0 / autoinc 1 / blank_only 0, FIFO empty, `fifo_level` = 0, `overflow` = 0, all enables 0, all write addr/data outputs 0, s1/s2/s3 = 0.
  - With s3 = 0 out of reset, no spurious commit occurs if `cs_clock` is high at reset release.
- **Reset asserted mid-operation:** state is discarded immediately; queued writes are lost and enables fall asynchronously.
- **Commit latency:** `cs_clock` falls before edge E0 → s1 = 0 after E0, s2 = 0 after E1, `commit` high in the cycle after E1 → register update and FIFO push at E2.
- **Write latency:** with the FIFO empty and drain permitted, the write enable is high in the cycle after E3, i.e. 4 edges after the `cs_clock` fall.
- **`fifo_level`:** updates on the same edge as push/pop.
- **Throughput:** one pop per clock. Successive CPU accesses need `cs_clock` low ≥3 and high ≥3 `CLK100MHz` cycles.
- **Blank gating:** with blank_only = 1 and `vga_blank` = 0, entries accumulate. Drain resumes on the first edge where `vga_blank` = 1, one per cycle.

## Test plan
- **Basic write:** ADDR_LO = 0x34, ADDR_HI = 0x02, CTRL = 0x00, DATA = 0xAB → `tile_memory_write_enable` high for exactly 1 cycle, 4 edges after the `cs_clock` fall, with addr 0x234 and data 0xAB; other enables stay 0.
- **Autoinc burst and wrap:** CTRL = 0x05, ptr = 0xFFE, DATA 0x11/0x22/0x33 → attribute writes at 0xFFE, 0xFFF, 0x000. Then CTRL = 0x06, DATA = 0x5A → color write at 0x1 (ptr[3:0]), data 0x5A.
- **Blank gating and overflow:** CTRL = 0x0C, `vga_blank` = 0, 18 DATA writes → `fifo_level` = 16, `overflow` = 1, no enables. Raise `vga_blank` → 16 consecutive tile writes at ptr values 0..15, in order. CTRL = 0x80 → `overflow` = 0.
- **Ignored accesses:** `rw` = 1 on addr 3; any write on addr 5; DATA with target 3 → no enable pulses, `fifo_level` stays 0; ptr advances only for the target-3 DATA write.
- **Reset mid-stream:** queue 5 entries under blank gating, assert `rst` mid-cycle → all enables 0 immediately, `fifo_level` = 0, ptr = 0. After release, `vga_blank` = 1 produces no writes.

Source files
------------

// File: rtl/gpu_bus_bridge.sv
// CPU-side register front end for the GPU memories: synchronizes the cs_clock strobe,
// decodes pointer/control/data registers and drains queued data writes into memory strobes.
`timescale 1ns/1ps
module gpu_bus_bridge #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic               CLK100MHz,
  input  logic               rst,
  input  logic [7:0]         data,
  input  logic [2:0]         addr,
  input  logic               rw,
  input  logic               cs_clock,
  input  logic               vga_blank,
  output logic               tile_memory_write_enable,
  output logic [10:0]        tile_memory_write_addr,
  output logic [7:0]         tile_memory_write_data,
  output logic               attribute_memory_write_enable,
  output logic [11:0]        attribute_memory_write_addr,
  output logic [7:0]         attribute_memory_write_data,
  output logic               color_memory_write_enable,
  output logic [3:0]         color_memory_write_addr,
  output logic [7:0]         color_memory_write_data,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               overflow
);

  localparam int ENTRY_W = 22;
  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(FIFO_DEPTH);

  logic               s1_r, s2_r, s3_r;
  logic [2:0]         hold_addr_r;
  logic [7:0]         hold_data_r;
  logic               hold_rw_r;
  logic [11:0]        ptr_r;
  logic [1:0]         target_r;
  logic               autoinc_r;
  logic               blank_only_r;
  logic               overflow_r;
  logic [ENTRY_W-1:0] fifo_mem_r [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_idx_r, rd_idx_r;
  logic [FIFO_AW:0]   count_r;

  logic               commit_s, wr_cmd_s, data_wr_s, push_req_s;
  logic               full_s, empty_s, push_s, pop_s, drop_s;
  logic [ENTRY_W-1:0] head_s;
  logic [1:0]         head_tgt_s;
  logic [11:0]        head_ptr_s;
  logic [7:0]         head_data_s;

  // Strobe synchronizer and bus holding registers
  always_ff @(posedge CLK100MHz or posedge rst) begin
    if (rst) begin
      s1_r        <= 1'b0;
      s2_r        <= 1'b0;
      s3_r        <= 1'b0;
      hold_addr_r <= 3'd0;
      hold_data_r <= 8'd0;
      hold_rw_r   <= 1'b0;
    end else begin
      s1_r <= cs_clock;
      s2_r <= s1_r;
      s3_r <= s2_r;
      if (s1_r) begin
        hold_addr_r <= addr;
        hold_data_r <= data;
        hold_rw_r   <= rw;
      end
    end
  end

  // Command decode, FIFO status and drain permission
  always_comb begin
    commit_s   = s3_r & ~s2_r;
    wr_cmd_s   = commit_s & ~hold_rw_r;
    data_wr_s  = wr_cmd_s && (hold_addr_r == 3'd3);
    push_req_s = data_wr_s && (target_r != 2'd3);
    full_s     = (count_r == DEPTH_C);
    empty_s    = (count_r == '0);
    push_s     = push_req_s & ~full_s;
    drop_s     = push_req_s & full_s;
    head_s     = fifo_mem_r[rd_idx_r];
    head_tgt_s  = head_s[21:20];
    head_ptr_s  = head_s[19:8];
    head_data_s = head_s[7:0];
    if (!empty_s && (!blank_only_r || vga_blank)) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Register file: pointer, control and sticky overflow
  always_ff @(posedge CLK100MHz or posedge rst) begin
    if (rst) begin
      ptr_r        <= 12'd0;
      target_r     <= 2'd0;
      autoinc_r    <= 1'b1;
      blank_only_r <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      if (wr_cmd_s) begin
        case (hold_addr_r)
          3'd0: ptr_r[7:0]  <= hold_data_r;
          3'd1: ptr_r[11:8] <= hold_data_r[3:0];
          3'd2: begin
            target_r     <= hold_data_r[1:0];
            autoinc_r    <= hold_data_r[2];
            blank_only_r <= hold_data_r[3];
            if (hold_data_r[7]) overflow_r <= 1'b0;
          end
          // Pointer advances even for discarded or dropped writes to keep CPU streams aligned
          3'd3: if (autoinc_r) ptr_r <= ptr_r + 12'd1;
          default: ;
        endcase
      end
      if (drop_s) overflow_r <= 1'b1;
    end
  end

  // FIFO storage; contents need no reset since the indices and count gate all reads
  always_ff @(posedge CLK100MHz) begin
    if (push_s) fifo_mem_r[wr_idx_r] <= {target_r, ptr_r, hold_data_r};
  end

  // FIFO indices and occupancy
  always_ff @(posedge CLK100MHz or posedge rst) begin
    if (rst) begin
      wr_idx_r <= '0;
      rd_idx_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) wr_idx_r <= wr_idx_r + 1'b1;
      if (pop_s)  rd_idx_r <= rd_idx_r + 1'b1;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Memory write strobes; address/data hold their last value when idle
  always_ff @(posedge CLK100MHz or posedge rst) begin
    if (rst) begin
      tile_memory_write_enable      <= 1'b0;
      tile_memory_write_addr        <= 11'd0;
      tile_memory_write_data        <= 8'd0;
      attribute_memory_write_enable <= 1'b0;
      attribute_memory_write_addr   <= 12'd0;
      attribute_memory_write_data   <= 8'd0;
      color_memory_write_enable     <= 1'b0;
      color_memory_write_addr       <= 4'd0;
      color_memory_write_data       <= 8'd0;
    end else begin
      tile_memory_write_enable      <= pop_s && (head_tgt_s == 2'd0);
      attribute_memory_write_enable <= pop_s && (head_tgt_s == 2'd1);
      color_memory_write_enable     <= pop_s && (head_tgt_s == 2'd2);
      if (pop_s) begin
        case (head_tgt_s)
          2'd0: begin
            tile_memory_write_addr <= head_ptr_s[10:0];
            tile_memory_write_data <= head_data_s;
          end
          2'd1: begin
            attribute_memory_write_addr <= head_ptr_s;
            attribute_memory_write_data <= head_data_s;
          end
          2'd2: begin
            color_memory_write_addr <= head_ptr_s[3:0];
            color_memory_write_data <= head_data_s;
          end
          default: ;
        endcase
      end
    end
  end

  assign fifo_level = count_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_gpu_bus_bridge.sv
// Directed bench for gpu_bus_bridge: a reference model of pointer/control state feeds
// a scoreboard of expected memory writes, compared when the bridge strobes a write.
`timescale 1ns/1ps
module tb_gpu_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data;
  logic [2:0]  addr;
  logic        rw;
  logic        cs_clock;
  logic        vga_blank;
  logic        tile_en, attr_en, color_en;
  logic [10:0] tile_addr;
  logic [11:0] attr_addr;
  logic [3:0]  color_addr;
  logic [7:0]  tile_data, attr_data, color_data;
  logic [4:0]  fifo_level;
  logic        overflow;

  typedef struct packed {
    logic [1:0]  tgt;
    logic [11:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        sb_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_pulses = 0;
  int          n_en;
  int          pulses_before;
  logic [1:0]  obs_tgt;
  logic [11:0] obs_addr;
  logic [7:0]  obs_data;
  logic [11:0] m_ptr;
  logic [1:0]  m_tgt;
  logic        m_autoinc;

  always #5 clk = ~clk;

  gpu_bus_bridge #(.FIFO_DEPTH(16), .FIFO_AW(4)) dut (
    .CLK100MHz                     (clk),
    .rst                           (rst),
    .data                          (data),
    .addr                          (addr),
    .rw                            (rw),
    .cs_clock                      (cs_clock),
    .vga_blank                     (vga_blank),
    .tile_memory_write_enable      (tile_en),
    .tile_memory_write_addr        (tile_addr),
    .tile_memory_write_data        (tile_data),
    .attribute_memory_write_enable (attr_en),
    .attribute_memory_write_addr   (attr_addr),
    .attribute_memory_write_data   (attr_data),
    .color_memory_write_enable     (color_en),
    .color_memory_write_addr       (color_addr),
    .color_memory_write_data       (color_data),
    .fifo_level                    (fifo_level),
    .overflow                      (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected entry
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      n_en = int'(tile_en) + int'(attr_en) + int'(color_en);
      if (n_en != 0) begin
        n_pulses += n_en;
        chk("one_enable", n_en, 1);
        obs_tgt  = tile_en ? 2'd0 : (attr_en ? 2'd1 : 2'd2);
        obs_addr = tile_en ? {1'b0, tile_addr} : (attr_en ? attr_addr : {8'd0, color_addr});
        obs_data = tile_en ? tile_data : (attr_en ? attr_data : color_data);
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $error("FAIL unexpected_write: observed tgt %0d addr %0h data %0h expected none",
                 obs_tgt, obs_addr, obs_data);
        end else begin
          sb_e = sb_q.pop_front();
          chk("sb_target", obs_tgt, sb_e.tgt);
          chk("sb_addr", obs_addr, sb_e.addr);
          chk("sb_data", obs_data, sb_e.data);
        end
      end
    end
  end

  task automatic strobe(input logic [2:0] a, input logic [7:0] d, input logic r, input int low_cyc);
    @(negedge clk);
    addr = a; data = d; rw = r; cs_clock = 1'b1;
    repeat (4) @(negedge clk);
    cs_clock = 1'b0;
    repeat (low_cyc) @(negedge clk);
  endtask

  task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
    case (a)
      3'd0: m_ptr[7:0]  = d;
      3'd1: m_ptr[11:8] = d[3:0];
      3'd2: begin m_tgt = d[1:0]; m_autoinc = d[2]; end
      default: ;
    endcase
    strobe(a, d, 1'b0, 4);
  endtask

  task automatic expect_data(input logic [7:0] d, input logic dropped);
    exp_t e;
    if (m_tgt != 2'd3 && !dropped) begin
      e.tgt  = m_tgt;
      e.data = d;
      case (m_tgt)
        2'd0:    e.addr = {1'b0, m_ptr[10:0]};
        2'd1:    e.addr = m_ptr;
        default: e.addr = {8'd0, m_ptr[3:0]};
      endcase
      sb_q.push_back(e);
    end
    if (m_autoinc) m_ptr = m_ptr + 12'd1;
  endtask

  task automatic data_wr(input logic [7:0] d, input logic dropped);
    expect_data(d, dropped);
    strobe(3'd3, d, 1'b0, 4);
  endtask

  initial begin
    rst = 1'b1; data = 8'd0; addr = 3'd0; rw = 1'b0; cs_clock = 1'b0; vga_blank = 1'b0;
    m_ptr = 12'd0; m_tgt = 2'd0; m_autoinc = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tile_en", tile_en, 0);
    chk("rst_attr_en", attr_en, 0);
    chk("rst_color_en", color_en, 0);
    chk("rst_tile_addr", tile_addr, 0);
    chk("rst_attr_addr", attr_addr, 0);
    chk("rst_color_addr", color_addr, 0);
    chk("rst_data", {tile_data, attr_data, color_data}, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Basic write with latency check: enable high after the 4th edge following the fall
    cpu_wr(3'd0, 8'h34);
    cpu_wr(3'd1, 8'h02);
    cpu_wr(3'd2, 8'h00);
    expect_data(8'hAB, 1'b0);
    strobe(3'd3, 8'hAB, 1'b0, 0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("basic_latency", tile_en, (k == 4) ? 1 : 0);
    end
    chk("basic_addr_hold", tile_addr, 11'h234);

    // Autoinc burst across the 0xFFF wrap, then a color write
    cpu_wr(3'd2, 8'h05);
    cpu_wr(3'd0, 8'hFE);
    cpu_wr(3'd1, 8'h0F);
    data_wr(8'h11, 1'b0);
    data_wr(8'h22, 1'b0);
    data_wr(8'h33, 1'b0);
    cpu_wr(3'd2, 8'h06);
    data_wr(8'h5A, 1'b0);
    repeat (4) @(negedge clk);
    chk("burst_drained", sb_q.size(), 0);
    chk("color_addr", color_addr, 4'h1);

    // Blank gating and overflow
    cpu_wr(3'd0, 8'h00);
    cpu_wr(3'd1, 8'h00);
    cpu_wr(3'd2, 8'h0C);
    pulses_before = n_pulses;
    for (int i = 0; i < 18; i++) data_wr(8'(i), (i >= 16) ? 1'b1 : 1'b0);
    chk("gate_level", fifo_level, 16);
    chk("gate_overflow", overflow, 1);
    chk("gate_no_writes", n_pulses, pulses_before);
    vga_blank = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("drain_consecutive", tile_en, 1);
    end
    @(negedge clk);
    chk("drain_stop", tile_en, 0);
    chk("drain_level", fifo_level, 0);
    chk("drain_sb_empty", sb_q.size(), 0);
    vga_blank = 1'b0;
    cpu_wr(3'd2, 8'h80);
    chk("overflow_clear", overflow, 0);

    // Ignored accesses: read cycle, unused address, discard target
    cpu_wr(3'd0, 8'h10);
    cpu_wr(3'd1, 8'h00);
    pulses_before = n_pulses;
    strobe(3'd3, 8'h99, 1'b1, 4);
    cpu_wr(3'd5, 8'h42);
    cpu_wr(3'd2, 8'h07);
    data_wr(8'h55, 1'b0);
    repeat (4) @(negedge clk);
    chk("ignored_level", fifo_level, 0);
    chk("ignored_no_writes", n_pulses, pulses_before);
    cpu_wr(3'd2, 8'h04);
    data_wr(8'h66, 1'b0);
    repeat (4) @(negedge clk);
    chk("ptr_advance_once", tile_addr, 11'h011);
    chk("ignored_sb_empty", sb_q.size(), 0);

    // Reset while draining
    cpu_wr(3'd2, 8'h0C);
    for (int i = 0; i < 5; i++) strobe(3'd3, 8'(8'hC0 + i), 1'b0, 4);
    chk("mid_level", fifo_level, 5);
    vga_blank = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_enable", {tile_en, attr_en, color_en}, 0);
    chk("mid_rst_level", fifo_level, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_ptr = 12'd0; m_tgt = 2'd0; m_autoinc = 1'b1;
    pulses_before = n_pulses;
    repeat (10) @(negedge clk);
    chk("post_rst_no_writes", n_pulses, pulses_before);
    chk("post_rst_level", fifo_level, 0);
    data_wr(8'h77, 1'b0);
    repeat (4) @(negedge clk);
    chk("post_rst_ptr_zero", tile_addr, 11'h000);
    chk("final_sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
